// File: rtl/lc3_dmem_responder.sv
// LC3 data-memory responder: accepts read/write requests, inserts a programmable
// number of wait states, performs the access on an internal word array and returns
// a single-cycle completion with registered read data and address-error flag.
module lc3_dmem_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned WAIT_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 data_req,
  input  logic                 data_rd,
  input  logic [15:0]          data_addr,
  input  logic [15:0]          data_din,
  input  logic [WAIT_BITS-1:0] wait_cfg,
  output logic [15:0]          data_dout,
  output logic                 complete_data,
  output logic                 addr_err,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e               state_q;
  logic [WAIT_BITS-1:0] wcnt_q;
  logic                 rd_q;
  logic [15:0]          addr_q;
  logic [15:0]          din_q;

  // Array is deliberately never reset so it can be preloaded.
  logic [15:0] mem_q [Depth];

  logic                 accept;
  logic                 commit;
  logic                 c_rd;
  logic [15:0]          c_addr;
  logic [15:0]          c_din;
  logic [ADDR_BITS-1:0] c_idx;
  logic                 c_oob;

  // Access attributes: straight from the inputs when committing in the accept cycle
  // (zero wait states), otherwise from the captured request.
  always_comb begin
    accept = (state_q == StIdle) && data_req;
    commit = (accept && (wait_cfg == '0)) ||
             ((state_q == StWait) && (wcnt_q == WAIT_BITS'(1)));
    c_rd   = accept ? data_rd   : rd_q;
    c_addr = accept ? data_addr : addr_q;
    c_din  = accept ? data_din  : din_q;
    c_idx  = c_addr[ADDR_BITS-1:0];
    c_oob  = (c_addr >> ADDR_BITS) != 16'h0000;
  end

  // Request FSM with registered outputs; the array access commits on the edge entering RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      wcnt_q        <= '0;
      rd_q          <= 1'b0;
      addr_q        <= 16'h0000;
      din_q         <= 16'h0000;
      data_dout     <= 16'h0000;
      complete_data <= 1'b0;
      addr_err      <= 1'b0;
      rd_count      <= 16'h0000;
      wr_count      <= 16'h0000;
    end else begin
      if (commit) begin
        if (c_rd) begin
          data_dout <= c_oob ? 16'h0000 : mem_q[c_idx];
        end else if (!c_oob) begin
          mem_q[c_idx] <= c_din;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (data_req) begin
            rd_q   <= data_rd;
            addr_q <= data_addr;
            din_q  <= data_din;
            wcnt_q <= wait_cfg;
            if (wait_cfg == '0) begin
              state_q       <= StResp;
              complete_data <= 1'b1;
              addr_err      <= c_oob;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          wcnt_q <= wcnt_q - WAIT_BITS'(1);
          if (wcnt_q == WAIT_BITS'(1)) begin
            state_q       <= StResp;
            complete_data <= 1'b1;
            addr_err      <= c_oob;
          end
        end
        StResp: begin
          complete_data <= 1'b0;
          addr_err      <= 1'b0;
          if (rd_q) begin
            rd_count <= rd_count + 16'd1;
          end else begin
            wr_count <= wr_count + 16'd1;
          end
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Self-checking bench for lc3_dmem_responder: directed scenarios plus randomized
// accesses compared against a word-array reference model kept in the bench.
module tb_lc3_dmem_responder;

  localparam int unsigned AddrBits = 8;
  localparam int unsigned WaitBits = 4;

  logic                clock;
  logic                reset;
  logic                data_req;
  logic                data_rd;
  logic [15:0]         data_addr;
  logic [15:0]         data_din;
  logic [WaitBits-1:0] wait_cfg;
  logic [15:0]         data_dout;
  logic                complete_data;
  logic                addr_err;
  logic [15:0]         rd_count;
  logic [15:0]         wr_count;

  lc3_dmem_responder #(
    .ADDR_BITS(AddrBits),
    .WAIT_BITS(WaitBits)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data_req     (data_req),
    .data_rd      (data_rd),
    .data_addr    (data_addr),
    .data_din     (data_din),
    .wait_cfg     (wait_cfg),
    .data_dout    (data_dout),
    .complete_data(complete_data),
    .addr_err     (addr_err),
    .rd_count     (rd_count),
    .wr_count     (wr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  logic [15:0] m_mem [256];
  logic [15:0] m_rd;
  logic [15:0] m_wr;
  logic [15:0] m_dout;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One LC3-style access: hold the request until completion, then drop it.
  task automatic access(input bit rd, input logic [15:0] addr, input logic [15:0] din,
                        input int w, input bit perturb, input string tag);
    int lat;
    bit oob;
    oob = (addr[15:8] != 8'h00);
    @(negedge clock);
    data_req  = 1'b1;
    data_rd   = rd;
    data_addr = addr;
    data_din  = din;
    wait_cfg  = WaitBits'(w);
    if (rd) begin
      m_dout = oob ? 16'h0000 : m_mem[addr[7:0]];
    end else if (!oob) begin
      m_mem[addr[7:0]] = din;
    end
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (complete_data) begin
        lat = n;
        break;
      end
      if (perturb) begin
        data_addr = 16'($urandom);
        data_din  = 16'($urandom);
        data_rd   = 1'($urandom);
        wait_cfg  = WaitBits'($urandom);
      end
    end
    check_eq({tag, " latency"}, 32'(lat), 32'(w));
    check_eq({tag, " addr_err"}, 32'(addr_err), 32'(oob));
    check_eq({tag, " dout"}, 32'(data_dout), 32'(m_dout));
    @(negedge clock);
    data_req = 1'b0;
    if (rd) m_rd = m_rd + 16'd1;
    else    m_wr = m_wr + 16'd1;
    @(posedge clock);
    #1;
    check_eq({tag, " complete drop"}, 32'(complete_data), 32'd0);
    check_eq({tag, " addr_err drop"}, 32'(addr_err), 32'd0);
    check_eq({tag, " rd_count"}, 32'(rd_count), 32'(m_rd));
    check_eq({tag, " wr_count"}, 32'(wr_count), 32'(m_wr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int doubles;
    bit prev;
    bit seen;
    logic [15:0] a;
    int w;

    reset     = 1'b0;
    data_req  = 1'b0;
    data_rd   = 1'b0;
    data_addr = 16'h0000;
    data_din  = 16'h0000;
    wait_cfg  = '0;
    m_rd      = 16'h0000;
    m_wr      = 16'h0000;
    m_dout    = 16'h0000;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset complete", 32'(complete_data), 32'd0);
    check_eq("reset addr_err", 32'(addr_err), 32'd0);
    check_eq("reset dout", 32'(data_dout), 32'd0);
    check_eq("reset rd_count", 32'(rd_count), 32'd0);
    check_eq("reset wr_count", 32'(wr_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Preload every word through the bus so the model knows the whole array.
    for (int i = 0; i < 256; i++) begin
      access(1'b0, 16'(i), 16'($urandom), 0, 1'b0, "preload");
    end

    // Reset in the second WAIT cycle of a W=3 write.
    @(negedge clock);
    data_req  = 1'b1;
    data_rd   = 1'b0;
    data_addr = 16'h0010;
    data_din  = 16'hBEEF;
    wait_cfg  = WaitBits'(3);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset    = 1'b0;
    data_req = 1'b0;
    m_rd     = 16'h0000;
    m_wr     = 16'h0000;
    m_dout   = 16'h0000;
    #1;
    check_eq("midwait rd_count", 32'(rd_count), 32'd0);
    check_eq("midwait wr_count", 32'(wr_count), 32'd0);
    check_eq("midwait dout", 32'(data_dout), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      if (complete_data) seen = 1'b1;
    end
    check_eq("midwait no complete", 32'(seen), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    access(1'b1, 16'h0010, 16'h0000, 0, 1'b0, "midwait readback");

    // Zero-wait write then read.
    access(1'b0, 16'h0005, 16'h1234, 0, 1'b0, "w0 write");
    access(1'b1, 16'h0005, 16'h0000, 0, 1'b0, "w0 read");
    check_eq("w0 read value", 32'(data_dout), 32'h1234);

    // Top in-range word, five waits, request inputs scrambled during WAIT.
    access(1'b0, 16'h00FF, 16'hA5A5, 1, 1'b0, "w5 setup");
    access(1'b1, 16'h00FF, 16'h0000, 5, 1'b1, "w5 read");
    check_eq("w5 read value", 32'(data_dout), 32'hA5A5);

    // Out-of-range write is dropped; out-of-range read returns zero.
    access(1'b0, 16'h0100, 16'hFFFF, 0, 1'b0, "oob write");
    access(1'b1, 16'h0000, 16'h0000, 0, 1'b0, "oob check mem0");
    access(1'b1, 16'h0100, 16'h0000, 2, 1'b0, "oob read");
    check_eq("oob read value", 32'(data_dout), 32'h0000);

    // Maximum wait setting.
    access(1'b1, 16'h0005, 16'h0000, 15, 1'b1, "wmax read");

    // Randomized accesses.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) a = {8'($urandom_range(1, 255)), 8'($urandom)};
      else                           a = {8'h00, 8'($urandom)};
      if ($urandom_range(0, 3) == 0) w = $urandom_range(0, 15);
      else                           w = $urandom_range(0, 2);
      access(1'($urandom), a, 16'($urandom), w, 1'($urandom), "rand");
    end

    // Back-to-back reads with the request held high through RESP.
    @(negedge clock);
    data_req  = 1'b1;
    data_rd   = 1'b1;
    data_addr = 16'h0005;
    wait_cfg  = '0;
    pulses  = 0;
    doubles = 0;
    prev    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (complete_data && prev) doubles++;
      if (complete_data) pulses++;
      prev = complete_data;
    end
    @(negedge clock);
    data_req = 1'b0;
    m_rd = m_rd + 16'(pulses);
    @(posedge clock);
    #1;
    check_eq("b2b pulses", 32'(pulses), 32'd10);
    check_eq("b2b doubles", 32'(doubles), 32'd0);
    check_eq("b2b dout", 32'(data_dout), 32'(m_mem[8'h05]));
    check_eq("b2b rd_count", 32'(rd_count), 32'(m_rd));
    check_eq("b2b wr_count", 32'(wr_count), 32'(m_wr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_dmem_responder.md
# lc3_dmem_responder

Synthesizable data-memory responder for the LC3 memory-access stage: the slave end of the dmem interface that the `dmem_agent_BFM` drives in simulation. It accepts read/write requests from the LC3 memaccess stage, inserts a configurable number of wait states, and performs the access on an internal word array. It then returns a single-cycle completion. It allows the LC3 to run standalone in emulation and lets the dmem agent run passive against real RTL timing.

## Interface
Parameters:
- `ADDR_BITS`, 8: index width; the array holds 2^ADDR_BITS 16-bit words.
- `WAIT_BITS`, 4: width of the wait-state configuration.

Ports:
- `clock`  in  1  the only clock; rising edge.
- `reset`  in  1  asynchronous assert, active-low (0 = reset).
- `data_req`  in  1  request valid; held high by the LC3 until it samples `complete_data`.
- `data_rd`  in  1  1 = read, 0 = write; qualified by `data_req`.
- `data_addr`  in  16  word address.
- `data_din`  in  16  write data from the LC3.
- `wait_cfg`  in  WAIT_BITS  wait states inserted per access; sampled at acceptance.
- `data_dout`  out  16  read data; valid while `complete_data`=1, holds afterward.
- `complete_data`  out  1  one-cycle completion pulse.
- `addr_err`  out  1  pulses with `complete_data` when the address is out of range.
- `rd_count`  out  16  completed reads, wraps at 16'hFFFF→0.
- `wr_count`  out  16  completed writes, wraps at 16'hFFFF→0.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If `data_req`=1, capture `data_rd`, `data_addr`, `data_din`, and load `wcnt`←`wait_cfg`.
  - Go to RESP if `wait_cfg`=0, otherwise go to WAIT.
- WAIT: `wcnt` decrements each cycle. When `wcnt`=1, go to RESP.
- Access commit happens on the edge that enters RESP:
  - Read: `data_dout` ← mem[addr[ADDR_BITS-1:0]].
  - Write: mem[addr[ADDR_BITS-1:0]] ← captured din.
  - Only captured values are used. Changes on the request inputs after acceptance are ignored.
- RESP:
  - `complete_data`=1 for exactly this cycle.
  - `addr_err` reflects the captured address.
  - `rd_count` or `wr_count` increments on the exit edge.
  - Always returns to IDLE.
- Out of range means captured `data_addr[15:ADDR_BITS]` ≠ 0:
  - A read returns 16'h0000.
  - A write is dropped and the array is unchanged.
  - `addr_err`=1 during RESP.
  - The count still increments.
- Back-to-back requests: in the IDLE cycle after RESP, `data_req`=1 is treated as a new request. The LC3 drops `data_req` in the cycle it samples `complete_data`.
- Read-after-write to the same address returns the written data. The write has committed before any later acceptance.
- Reset, whether at power-up or mid-access:
  - FSM → IDLE; `wcnt`=0.
  - Any pending write is discarded.
  - Outputs: `complete_data`=0, `addr_err`=0, `data_dout`=16'h0000, `rd_count`=0, `wr_count`=0.
  - Array contents are NOT cleared; they are preloadable by `$readmemh` in simulation.
- `data_req`=0 in IDLE: the FSM stays in IDLE and all outputs hold.

## Timing
- Request seen in IDLE at cycle T → `complete_data` high in cycle T+1+W, where W = sampled `wait_cfg`.
- W=0 gives 1-cycle latency; maximum latency is 2^WAIT_BITS cycles.
- Minimum request-to-request spacing is W+2 cycles: acceptance, W waits, then RESP.
- `data_dout`, `addr_err` and `complete_data` are all registered; there is no combinational input→output path.
- Reset is asynchronous on assertion. Deassertion is synchronized externally. The first acceptance can occur in the first cycle with `reset`=1.

## Test plan
- Reset mid-WAIT:
  - Stimulus: write 16'hBEEF to 0x0010 with W=3; assert `reset` in the second WAIT cycle; release, then read 0x0010.
  - Response: no `complete_data`; the read returns the old preloaded value; both counts are 0.
- W=0 write then read:
  - Stimulus: write 16'h1234 to 0x0005, then read 0x0005.
  - Response: each access completes 1 cycle after `data_req`; the read gives `data_dout`=16'h1234; `rd_count`=1 and `wr_count`=1.
- W=5 read:
  - Stimulus: read a preloaded 0x00FF (16'hA5A5); toggle `data_addr` and `wait_cfg` during WAIT.
  - Response: `complete_data` arrives exactly 6 cycles after acceptance; `data_dout`=16'hA5A5.
- Out-of-range access:
  - Stimulus: write 16'hFFFF to 0x0100 with ADDR_BITS=8, then read 0x0000.
  - Response: `addr_err` pulses with completion; mem[0x00] is unchanged; the read of 0x0100 returns 16'h0000 with `addr_err`=1.
- Back-to-back reads:
  - Stimulus: hold `data_req` high through RESP with W=0.
  - Response: `complete_data` pulses every 2 cycles and never stays high two cycles in a row.
- Counter wrap:
  - Stimulus: 65536 reads.
  - Response: `rd_count` returns to 16'h0000; `wr_count` is unchanged.
